// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered flags/count; optional checks under SYNC_FIFO_ASSERT_EN
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [CW-1:0]    count_nxt;

  // Accept decisions and next occupancy; a full FIFO still takes a write when a pop frees a slot
  always_comb begin
    rd_acc    = rd_en & ~fifo_empty;
    wr_acc    = wr_en & (~fifo_full | rd_acc);
    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - 1'b1;
    end
  end

  // Storage array is never reset; writes are blocked during the reset cycle
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wptr] <= wr_data;
    end
  end

  // Pointers, read register, count and flags; flags come from the next count so they stay registered
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + 1'b1;
      end
      count      <= count_nxt;
      fifo_empty <= (count_nxt == '0);
      fifo_full  <= (count_nxt == FULL_CNT);
    end
  end

`ifdef SYNC_FIFO_ASSERT_EN
  // Protocol-misuse and internal-consistency checks at the FIFO boundary
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(wr_en && fifo_full && !rd_en))
        else $error("%0t sync_fifo overflow attempt: wr_en=%b fifo_full=%b rd_en=%b count=%0d",
                    $time, wr_en, fifo_full, rd_en, count);
      assert (!(rd_en && fifo_empty))
        else $error("%0t sync_fifo underflow attempt: rd_en=%b fifo_empty=%b count=%0d",
                    $time, rd_en, fifo_empty, count);
      assert (count <= FULL_CNT)
        else $error("%0t sync_fifo count out of range: count=%0d", $time, count);
      assert (fifo_empty == (count == '0))
        else $error("%0t sync_fifo empty flag inconsistent: fifo_empty=%b count=%0d",
                    $time, fifo_empty, count);
      assert (fifo_full == (count == FULL_CNT))
        else $error("%0t sync_fifo full flag inconsistent: fifo_full=%b count=%0d",
                    $time, fifo_full, count);
    end
  end
`else
  // Checks compiled out; ignored accesses remain silently ignored
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CW-1:0]    count;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_rd;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .count      (count)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the scoreboard queue is updated with what the FIFO should accept
  task automatic drive(input logic w, input logic [WIDTH-1:0] d, input logic r);
    bit ra;
    bit wa;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    ra = r && (model_q.size() > 0);
    wa = w && ((model_q.size() < DEPTH) || ra);
    @(posedge clk);
    #1;
    if (ra) exp_rd = model_q.pop_front();
    if (wa) model_q.push_back(d);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic apply_reset(input int cycles, input logic w);
    rst   = 1'b1;
    wr_en = w;
    rd_en = 1'b1;
    wr_data = 8'hEE;
    repeat (cycles) @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_q.delete();
    exp_rd = '0;
  endtask

  task automatic test_reset();
    apply_reset(2, 1'b0);
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
  endtask

  task automatic test_fill_drain_overflow_underflow();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'h10 + WIDTH'(i), 1'b0);
      checks++; if (count !== CW'(model_q.size())) begin errors++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, model_q.size()); end
    end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", fifo_full); end
    checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL fill_count8 got=%0d exp=%0d", count, DEPTH); end
    drive(1'b1, 8'hAA, 1'b0);
    checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL overflow_count got=%0d exp=%0d", count, DEPTH); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL overflow_full got=%b exp=1", fifo_full); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1);
      checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, rd_data, exp_rd); end
      checks++; if (fifo_empty !== (model_q.size() == 0)) begin errors++; $display("FAIL drain_empty i=%0d got=%b exp=%b", i, fifo_empty, model_q.size() == 0); end
    end
    checks++; if (rd_data !== 8'h17) begin errors++; $display("FAIL drain_last got=%h exp=17", rd_data); end
    drive(1'b0, '0, 1'b1);
    checks++; if (rd_data !== 8'h17) begin errors++; $display("FAIL underflow_hold got=%h exp=17", rd_data); end
    checks++; if (count !== '0 || fifo_empty !== 1'b1) begin errors++; $display("FAIL underflow_state got=%0d/%b exp=0/1", count, fifo_empty); end
  endtask

  task automatic test_simultaneous();
    logic [WIDTH-1:0] held;
    held = rd_data;
    drive(1'b1, 8'h55, 1'b1);
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL simul_empty_count got=%0d exp=1", count); end
    checks++; if (rd_data !== held) begin errors++; $display("FAIL simul_empty_hold got=%h exp=%h", rd_data, held); end
    checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL simul_empty_flag got=%b exp=0", fifo_empty); end
    for (int i = 1; i < DEPTH; i++) drive(1'b1, 8'h60 + WIDTH'(i), 1'b0);
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL simul_prefull got=%b exp=1", fifo_full); end
    drive(1'b1, 8'h99, 1'b1);
    checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL simul_full_count got=%0d exp=%0d", count, DEPTH); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL simul_full_flag got=%b exp=1", fifo_full); end
    checks++; if (rd_data !== 8'h55) begin errors++; $display("FAIL simul_full_oldest got=%h exp=55", rd_data); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1);
      checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL simul_drain i=%0d got=%h exp=%h", i, rd_data, exp_rd); end
    end
    checks++; if (rd_data !== 8'h99) begin errors++; $display("FAIL simul_last got=%h exp=99", rd_data); end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] v;
    v = 8'hC0;
    for (int i = 0; i < 3; i++) begin drive(1'b1, v, 1'b0); v++; end
    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0: begin drive(1'b1, v, 1'b1); v++; end
        1: begin drive(1'b1, v, 1'b0); v++; end
        default: drive(1'b0, '0, 1'b1);
      endcase
      checks++;
      if (rd_data !== exp_rd || count !== CW'(model_q.size()) ||
          fifo_empty !== (model_q.size() == 0) || fifo_full !== (model_q.size() == DEPTH)) begin
        errors++;
        $display("FAIL wrap i=%0d got=%h/%0d/%b/%b exp=%h/%0d", i, rd_data, count, fifo_empty, fifo_full, exp_rd, model_q.size());
      end
    end
    while (model_q.size() > 0) begin
      drive(1'b0, '0, 1'b1);
      checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL wrap_drain got=%h exp=%h", rd_data, exp_rd); end
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", fifo_empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h30 + WIDTH'(i), 1'b0);
    checks++; if (count !== CW'(5)) begin errors++; $display("FAIL mid_pre_count got=%0d exp=5", count); end
    apply_reset(1, 1'b1);
    checks++; if (count !== '0) begin errors++; $display("FAIL mid_count got=%0d exp=0", count); end
    checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin errors++; $display("FAIL mid_flags got=%b/%b exp=1/0", fifo_empty, fifo_full); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL mid_rd_data got=%h exp=00", rd_data); end
    drive(1'b1, 8'h42, 1'b0);
    drive(1'b0, '0, 1'b1);
    checks++; if (rd_data !== 8'h42) begin errors++; $display("FAIL mid_push_pop got=%h exp=42", rd_data); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL mid_final_empty got=%b exp=1", fifo_empty); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; exp_rd = '0;
    test_reset();
    test_fill_drain_overflow_underflow();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
